ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one port of dual_port_distributed_ram (async read, sync write) among N_REQ requesters,
//  e.g. CPU data port, UART/debug loader and DMA. Round-robin, one access per cycle.
//  Per-requester valid/ready request channel, byte-strobed writes merged against the async read.
//  Registered response channel with backpressure. Sits between the requesters and RAM port 1.
// PARAMETERS
//  N_REQ   2    number of requesters (>=2)
//  W       32   data width; multiple of 8
//  L       128  RAM depth in words; ADDR_W = $clog2(L)
// PORTS
//  clk          in   1             clock
//  rst_n        in   1             async active-low reset
//  req_valid    in   N_REQ         request valid, per requester
//  req_ready    out  N_REQ         request accepted this cycle (valid&ready = handshake)
//  req_we       in   N_REQ         1 = write, 0 = read
//  req_addr     in   N_REQ*ADDR_W  word address
//  req_wdata    in   N_REQ*W       write data
//  req_strb     in   N_REQ*(W/8)   byte write enables; ignored on reads
//  rsp_valid    out  N_REQ         response valid, per requester
//  rsp_ready    in   N_REQ         response consumed
//  rsp_rdata    out  N_REQ*W       RAM word as it was before the access (read-before-write)
//  mem_wr_ena   out  1             RAM write enable
//  mem_addr     out  ADDR_W        RAM address
//  mem_wr_data  out  W             RAM write data (merged word)
//  mem_rd_data  in   W             RAM async read data at mem_addr
// BEHAVIOUR
//  Reset (rst_n low, async): rsp_valid=0, rsp_rdata=0, rr pointer=0, all req_ready=0, mem_wr_ena=0.
//   mem_wr_ena is gated by rst_n combinationally, so no RAM write occurs while reset is held.
//   A response pending at reset is lost; a requester whose request was not accepted must re-present it.
//  Per-requester FSM: IDLE -> (handshake) -> RESP -> (rsp_valid&rsp_ready) -> IDLE.
//   At most one outstanding access per requester. The requester is eligible only in IDLE with req_valid=1.
//  Arbitration (combinational): among eligible requesters, grant the first found searching from
//   pointer ptr upward, modulo N_REQ. req_ready is one-hot or zero and never depends on rsp_ready.
//   On a handshake by requester g: ptr <= (g+1) mod N_REQ. With no handshake, ptr holds.
//  Access (same cycle as the handshake): mem_addr = req_addr[g].
//   For a write: mem_wr_ena=1 and mem_wr_data byte b = strb[b] ? wdata byte b : mem_rd_data byte b.
//   A write with strb=0 performs no RAM write (mem_wr_ena=0) but still returns a response.
//   With no grant: mem_wr_ena=0, mem_addr=0.
//  Response: latency 1. On the edge after the handshake, rsp_valid[g]=1 and rsp_rdata[g]=mem_rd_data
//   sampled at the handshake edge (old contents, for reads and writes alike).
//   rsp_rdata is held stable while rsp_valid & !rsp_ready.
//  Simultaneous events: a requester whose rsp_valid&rsp_ready occur this cycle is still in RESP,
//   so it is not eligible until the next cycle (best case one request every 2 cycles per requester;
//   aggregate throughput is 1 per cycle).
//  Fairness: a continuously eligible requester is granted within N_REQ handshakes.
//  A request held valid while not ready must keep addr/we/data/strb stable (checked by assertion).
// STRUCTURE
//  ram_arb_pkg: localparams for default W/L, typedef enum {ARB_IDLE, ARB_RESP} arb_state_t,
//   function merge_bytes(old, new, strb).
//  Sub-module rr_arbiter #(N): inputs req[N]; outputs grant one-hot and grant_idx;
//   owns the ptr register; advance input pulses on a handshake.
//  Top: rr_arbiter, address/data muxes, byte merge, N_REQ per-requester state and response registers.
// TESTING (bench instantiates dual_port_distributed_ram; port 0 is used for backdoor checks)
//  1 Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, mem_wr_ena=0; no RAM change.
//  2 Single read: r0 reads addr 5 holding 0xDEADBEEF -> ready same cycle; rsp_valid[0] next cycle
//    with 0xDEADBEEF; rsp_valid holds through 3 cycles of rsp_ready=0.
//  3 Byte write: word 0x11223344 at addr 9; r1 writes 0xAABBCCDD with strb=4'b0101
//    -> RAM[9]=0x11BB33DD, rsp_rdata=0x11223344.
//  4 Contention: r0 and r1 both valid every cycle, rsp_ready=1 -> grants alternate r0,r1,r0,r1 from reset.
//    With N_REQ=3 and all valid, the grant order is 0,1,2,0.
//  5 Backpressure: r0 stays in RESP (rsp_ready=0) while r1 keeps requesting -> r1 is granted
//    on every possible cycle; r0 is not re-granted until its response is consumed.
//  6 Mid-op reset: assert rst_n during a handshake cycle for a write to addr 3
//    -> RAM[3] unchanged, rsp_valid=0 after release, ptr=0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_W = 32;
  localparam int unsigned DEF_L = 128;

  // merge_bytes works on this fixed width; callers zero-extend inputs and truncate the result.
  localparam int unsigned MERGE_MAX_W = 1024;
  localparam int unsigned MERGE_MAX_B = MERGE_MAX_W / 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_t;

  // Byte b of the result comes from new_word where strb[b] is set, else from old_word.
  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_B-1:0] strb
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < MERGE_MAX_B; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dual_port_distributed_ram.sv
// Distributed RAM: two ports, each with asynchronous read and synchronous write.
module dual_port_distributed_ram #(
  parameter int unsigned W = 32,
  parameter int unsigned L = 128,
  localparam int unsigned ADDR_W = $clog2(L)
) (
  input  logic              clk,
  input  logic              wr_ena_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [W-1:0]      wr_data_0,
  output logic [W-1:0]      rd_data_0,
  input  logic              wr_ena_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [W-1:0]      wr_data_1,
  output logic [W-1:0]      rd_data_1
);

  logic [W-1:0] mem [L];

  assign rd_data_0 = mem[addr_0];
  assign rd_data_1 = mem[addr_1];

  // Both ports write on the rising edge; same-address collisions are the user's problem.
  always_ff @(posedge clk) begin
    if (wr_ena_0) mem[addr_0] <= wr_data_0;
    if (wr_ena_1) mem[addr_1] <= wr_data_1;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  // Search upward from ptr; the first requester found wins.
  always_comb begin
    int unsigned cand;
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if ((grant == '0) && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Priority moves to the requester just after the one served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port among N_REQ requesters: round-robin, one access per cycle,
// byte-strobed read-modify-write against the async read, registered responses.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned L     = DEF_L,
  localparam int unsigned ADDR_W = $clog2(L),
  localparam int unsigned B      = W / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*W-1:0]      req_wdata,
  input  logic [N_REQ*B-1:0]      req_strb,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [N_REQ*W-1:0]      rsp_rdata,
  output logic                    mem_wr_ena,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [W-1:0]            mem_wr_data,
  input  logic [W-1:0]            mem_rd_data
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [W-1:0]      wdata_a [N_REQ];
  logic [B-1:0]      strb_a  [N_REQ];
  arb_state_t        state   [N_REQ];
  logic [W-1:0]      rdata_q [N_REQ];

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_wdata[i*W +: W];
    assign strb_a[i]  = req_strb[i*B +: B];
    // Reset masks eligibility so nothing is accepted while rst_n is held.
    assign eligible[i] = rst_n && req_valid[i] && (state[i] == ARB_IDLE);
    assign rsp_valid[i] = (state[i] == ARB_RESP);
    assign rsp_rdata[i*W +: W] = rdata_q[i];

    // A request left waiting must not change under the arbiter.
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ready[i]) |=>
        (!req_valid[i] || $stable({req_we[i], addr_a[i], wdata_a[i], strb_a[i]})));
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (eligible),
    .advance   (grant_any),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Every grant is a handshake: eligibility already requires req_valid.
  assign grant_any = |grant;
  assign req_ready = grant;

  // Drive the RAM port for the granted requester; writes merge strobed bytes into the old word.
  always_comb begin
    mem_addr    = '0;
    mem_wr_ena  = 1'b0;
    mem_wr_data = '0;
    if (grant_any) begin
      mem_addr    = addr_a[grant_idx];
      mem_wr_data = W'(merge_bytes(MERGE_MAX_W'(mem_rd_data),
                                   MERGE_MAX_W'(wdata_a[grant_idx]),
                                   MERGE_MAX_B'(strb_a[grant_idx])));
      mem_wr_ena  = rst_n && req_we[grant_idx] && (|strb_a[grant_idx]);
    end
  end

  // Per-requester IDLE/RESP state; the response captures the pre-access word at the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        state[i]   <= ARB_IDLE;
        rdata_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        case (state[i])
          ARB_IDLE: begin
            if (grant[i]) begin
              state[i]   <= ARB_RESP;
              rdata_q[i] <= mem_rd_data;
            end
          end
          ARB_RESP: begin
            if (rsp_ready[i]) state[i] <= ARB_IDLE;
          end
        endcase
      end
    end
  end

endmodule
